pcpi_div_radix: RTL and testbench

Parametrised PCPI co-processor for RISC-V M-extension DIV/DIVU/REM/REMU, the successor to the fixed 32-bit, 1-bit-per-cycle divider. Operand width and radix (quotient bits retired per cycle) are configurable. Divide-by-zero and signed overflow take a 2-cycle fast path. The block may abort mid-operation when the core withdraws the request. It sits on the core's PCPI bus alongside the multiplier.

---
 rtl/pcpi_div_pkg.sv | 41 ++++
 rtl/pcpi_div_step.sv | 58 +++++
 rtl/pcpi_div_radix.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_pcpi_div_radix.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_div_pkg.sv
// ---------------------------------------------------------------------------
// pcpi_div_pkg
// Shared definitions for the PCPI radix divider:
//   - FSM state encoding (IDLE, SETUP, RUN, DONE)
//   - RV32M/RV64M decode constants (opcode, funct7, funct3 for DIV/DIVU/REM/REMU)
//   - operation kind enum and small helpers to classify it
// ---------------------------------------------------------------------------
package pcpi_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Signed/unsigned x quotient/remainder.
  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/pcpi_div_step.sv
// ---------------------------------------------------------------------------
// pcpi_div_step
// Combinational block of BITS_PER_CYCLE chained restoring-division steps.
// Each step compares the (left-aligned, right-shifting) divisor with the
// partial remainder, subtracts when divisor <= remainder and sets the
// quotient bit selected by the one-hot mask; divisor and mask then shift
// right by one.
// Ports:
//   rem_in/rem_out  XLEN       partial remainder
//   div_in/div_out  2*XLEN-1   shifted divisor
//   quo_in/quo_out  XLEN       quotient accumulated so far
//   msk_in/msk_out  XLEN       one-hot mask of the next quotient bit
// ---------------------------------------------------------------------------
module pcpi_div_step
  import pcpi_div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [XLEN-1:0]   rem_in,
  input  logic [2*XLEN-2:0] div_in,
  input  logic [XLEN-1:0]   quo_in,
  input  logic [XLEN-1:0]   msk_in,
  output logic [XLEN-1:0]   rem_out,
  output logic [2*XLEN-2:0] div_out,
  output logic [XLEN-1:0]   quo_out,
  output logic [XLEN-1:0]   msk_out
);

  logic [XLEN-1:0]   rem_v;
  logic [2*XLEN-2:0] div_v;
  logic [XLEN-1:0]   quo_v;
  logic [XLEN-1:0]   msk_v;

  always_comb begin
    // NOTE: every variable gets a value before the loop so no latch is
    // inferred; blocking assignments here are what chain one stage's result
    // into the next stage within the same cycle.
    rem_v = rem_in;
    div_v = div_in;
    quo_v = quo_in;
    msk_v = msk_in;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div_v <= {{(XLEN-1){1'b0}}, rem_v}) begin
        // divisor <= remainder implies its upper bits are zero
        rem_v = rem_v - div_v[XLEN-1:0];
        quo_v = quo_v | msk_v;
      end
      div_v = div_v >> 1;
      msk_v = msk_v >> 1;
    end
    rem_out = rem_v;
    div_out = div_v;
    quo_out = quo_v;
    msk_out = msk_v;
  end

endmodule

// File: rtl/pcpi_div_radix.sv
// ---------------------------------------------------------------------------
// pcpi_div_radix
// PCPI co-processor for RISC-V DIV/DIVU/REM/REMU with configurable width
// (XLEN = 32 or 64) and radix (BITS_PER_CYCLE = 1, 2 or 4 quotient bits per
// RUN cycle). Divide-by-zero and signed overflow complete in 2 cycles.
// The operation is abandoned if pcpi_valid drops during SETUP or RUN.
//
// Optional feature: define PCPI_DIV_REM_CACHE_EN to keep the last completed
// result (rs1, rs2, signedness, unsigned quotient and remainder); a matching
// request then completes from SETUP in 2 cycles (e.g. DIV then REM).
//
// Ports:
//   clk         clock, rising edge
//   resetn      synchronous active-low reset
//   pcpi_valid  core request, held with stable insn/rs1/rs2 until ready
//   pcpi_insn   32-bit instruction word
//   pcpi_rs1    dividend (XLEN)
//   pcpi_rs2    divisor (XLEN)
//   pcpi_wr     write-back strobe, high together with pcpi_ready
//   pcpi_rd     result (XLEN), zero whenever pcpi_ready is low
//   pcpi_wait   instruction claimed; high from SETUP through DONE
//   pcpi_ready  single-cycle completion pulse
// ---------------------------------------------------------------------------
module pcpi_div_radix
  import pcpi_div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int DW    = 2 * XLEN - 1;
  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state;
  div_op_e         op_kind;
  logic            outsign;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q;
  logic [DW-1:0]   div_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] msk_q;

  // -------------------------------------------------------------------------
  // Decode (only acted upon in IDLE)
  // -------------------------------------------------------------------------
  logic    insn_match;
  div_op_e insn_kind;

  always_comb begin
    insn_match = 1'b0;
    insn_kind  = OP_DIV;
    if (pcpi_insn[6:0] == OPCODE_OP && pcpi_insn[31:25] == FUNCT7_MULDIV) begin
      case (pcpi_insn[14:12])
        F3_DIV:  begin insn_match = 1'b1; insn_kind = OP_DIV;  end
        F3_DIVU: begin insn_match = 1'b1; insn_kind = OP_DIVU; end
        F3_REM:  begin insn_match = 1'b1; insn_kind = OP_REM;  end
        F3_REMU: begin insn_match = 1'b1; insn_kind = OP_REMU; end
        default: ;
      endcase
    end
  end

  // Register-specifier fields are irrelevant to the divider.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // -------------------------------------------------------------------------
  // SETUP-cycle operand conditioning
  // -------------------------------------------------------------------------
  logic            op_signed;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] abs_rs1;
  logic [XLEN-1:0] abs_rs2;
  logic            setup_outsign;
  logic            div_zero;
  logic            sgn_ovf;

  assign op_signed = op_is_signed(op_kind);
  assign rs1_neg   = op_signed & pcpi_rs1[XLEN-1];
  assign rs2_neg   = op_signed & pcpi_rs2[XLEN-1];
  assign abs_rs1   = rs1_neg ? -pcpi_rs1 : pcpi_rs1;
  assign abs_rs2   = rs2_neg ? -pcpi_rs2 : pcpi_rs2;
  // Remainder takes the dividend's sign, quotient the xor of both signs.
  assign setup_outsign = op_is_rem(op_kind) ? rs1_neg : (rs1_neg ^ rs2_neg);
  assign div_zero  = (pcpi_rs2 == '0);
  assign sgn_ovf   = op_signed && (pcpi_rs1 == INT_MIN) && (pcpi_rs2 == '1);

  // Select quotient or remainder and apply the output sign.
  function automatic logic [XLEN-1:0] fmt_result(
    input div_op_e         op,
    input logic            neg,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    logic [XLEN-1:0] pick;
    pick = op_is_rem(op) ? r : q;
    return neg ? -pick : pick;
  endfunction

  // -------------------------------------------------------------------------
  // Restoring step datapath
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] rem_nxt;
  logic [DW-1:0]   div_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] msk_nxt;

  pcpi_div_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_in  (rem_q),
    .div_in  (div_q),
    .quo_in  (quo_q),
    .msk_in  (msk_q),
    .rem_out (rem_nxt),
    .div_out (div_nxt),
    .quo_out (quo_nxt),
    .msk_out (msk_nxt)
  );

  // Last RUN cycle of a request that is still being held by the core.
  logic run_last;
  assign run_last = (state == S_RUN) && pcpi_valid && (count == CW'(1));

  // -------------------------------------------------------------------------
  // Result cache
  // -------------------------------------------------------------------------
`ifdef PCPI_DIV_REM_CACHE_EN
  logic            cache_valid;
  logic [XLEN-1:0] cache_rs1;
  logic [XLEN-1:0] cache_rs2;
  logic            cache_signed;
  logic [XLEN-1:0] cache_quo;
  logic [XLEN-1:0] cache_rem;
  logic            cache_hit;

  assign cache_hit = cache_valid && (cache_rs1 == pcpi_rs1) &&
                     (cache_rs2 == pcpi_rs2) && (cache_signed == op_signed);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cache_valid <= 1'b0;
    end else if (run_last) begin
      cache_valid <= 1'b1;
    end
  end

  // NOTE: the cache payload is deliberately left out of reset; cache_valid
  // alone gates its use, so resetting the wide data registers buys nothing.
  always_ff @(posedge clk) begin
    if (run_last) begin
      cache_rs1    <= pcpi_rs1;
      cache_rs2    <= pcpi_rs2;
      cache_signed <= op_signed;
      cache_quo    <= quo_nxt;
      cache_rem    <= rem_nxt;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Control FSM with registered PCPI outputs
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      op_kind    <= OP_DIV;
      outsign    <= 1'b0;
      count      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      msk_q      <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
    end else begin
      // Completion outputs are single-cycle pulses unless re-asserted below.
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;

      case (state)
        S_IDLE: begin
          if (pcpi_valid && insn_match) begin
            op_kind   <= insn_kind;
            pcpi_wait <= 1'b1;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (!pcpi_valid) begin
            pcpi_wait <= 1'b0;
            state     <= S_IDLE;
          end else begin
            outsign <= setup_outsign;
            if (div_zero) begin
              // quotient all-ones, remainder is the raw dividend
              pcpi_rd    <= op_is_rem(op_kind) ? pcpi_rs1 : '1;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              state      <= S_DONE;
            end else if (sgn_ovf) begin
              // quotient wraps to the dividend, remainder is zero
              pcpi_rd    <= op_is_rem(op_kind) ? '0 : pcpi_rs1;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              state      <= S_DONE;
`ifdef PCPI_DIV_REM_CACHE_EN
            end else if (cache_hit) begin
              pcpi_rd    <= fmt_result(op_kind, setup_outsign, cache_quo, cache_rem);
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              state      <= S_DONE;
`endif
            end else begin
              // Divisor starts aligned so its LSB sits under the dividend MSB.
              rem_q <= abs_rs1;
              div_q <= {abs_rs2, {(XLEN-1){1'b0}}};
              quo_q <= '0;
              msk_q <= {1'b1, {(XLEN-1){1'b0}}};
              count <= CW'(STEPS);
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (!pcpi_valid) begin
            pcpi_wait <= 1'b0;
            state     <= S_IDLE;
          end else begin
            rem_q <= rem_nxt;
            div_q <= div_nxt;
            quo_q <= quo_nxt;
            msk_q <= msk_nxt;
            count <= count - CW'(1);
            if (run_last) begin
              pcpi_rd    <= fmt_result(op_kind, outsign, quo_nxt, rem_nxt);
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              state      <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // No decode here even if pcpi_valid is still high.
          pcpi_wait <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          pcpi_wait <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_div_radix.sv
// ---------------------------------------------------------------------------
// tb_pcpi_div_radix
// Directed self-checking bench for pcpi_div_radix at XLEN=32. Expected results
// and latencies are hand-computed; latency is counted in cycles after the
// cycle T in which the request is sampled. Cached-hit latencies follow
// PCPI_DIV_REM_CACHE_EN.
// ---------------------------------------------------------------------------
module tb_pcpi_div_radix;
  import pcpi_div_pkg::*;

  localparam int BPC      = 1;
  localparam int FULL_LAT = 2 + 32 / BPC;
  localparam int FAST_LAT = 2;
`ifdef PCPI_DIV_REM_CACHE_EN
  localparam int HIT_LAT  = 2;
`else
  localparam int HIT_LAT  = FULL_LAT;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  pcpi_div_radix #(
    .XLEN           (32),
    .BITS_PER_CYCLE (BPC)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {FUNCT7_MULDIV, 5'd2, 5'd1, f3, 5'd3, OPCODE_OP};
  endfunction

  // Called just after edge T. Returns the cycle offset of pcpi_ready, the
  // result, and whether wait/wr/rd behaved while waiting. Stops at the
  // negedge of the ready cycle.
  task automatic wait_ready(output int lat, output logic [31:0] rd, output logic ok);
    lat = -1;
    rd  = '0;
    ok  = 1'b1;
    for (int c = 1; c <= 80 && lat < 0; c++) begin
      @(negedge clk);
      if (pcpi_wait !== 1'b1) ok = 1'b0;
      if (pcpi_wr !== pcpi_ready) ok = 1'b0;
      if (pcpi_ready === 1'b1) begin
        lat = c;
        rd  = pcpi_rd;
      end else if (pcpi_rd !== 32'd0) begin
        ok = 1'b0;
      end
    end
  endtask

  // One complete request; ok also covers wait/ready/rd low the cycle after.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rd, output logic ok);
    logic wok;
    @(posedge clk);
    #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    @(posedge clk);  // edge ending cycle T
    wait_ready(lat, rd, wok);
    pcpi_valid = 1'b0;
    @(negedge clk);
    ok = wok && (pcpi_wait === 1'b0) && (pcpi_ready === 1'b0) && (pcpi_rd === 32'd0);
  endtask

  task automatic test_reset;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pcpi_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b want 0", pcpi_wait); end
    checks++;
    if (pcpi_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", pcpi_ready); end
    checks++;
    if (pcpi_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", pcpi_wr); end
    checks++;
    if (pcpi_rd !== 32'd0) begin errors++; $display("FAIL reset_rd got %h want 0", pcpi_rd); end
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Runs a table of requests and checks result, latency and handshake.
  task automatic test_arith;
    vec_t        tab [13];
    int          lat;
    logic [31:0] rd;
    logic        ok;
    tab[0]  = '{F3_DIVU, 32'd100,        32'd7,          32'd14,         FULL_LAT};
    tab[1]  = '{F3_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  FULL_LAT};
    tab[2]  = '{F3_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  HIT_LAT};
    tab[3]  = '{F3_DIV,  32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  FULL_LAT};
    tab[4]  = '{F3_REM,  32'd20,         32'hFFFF_FFFD,  32'd2,          HIT_LAT};
    tab[5]  = '{F3_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,          FULL_LAT};
    tab[6]  = '{F3_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  FAST_LAT};
    tab[7]  = '{F3_REMU, 32'd5,          32'd0,          32'd5,          FAST_LAT};
    tab[8]  = '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  FAST_LAT};
    tab[9]  = '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          FAST_LAT};
    tab[10] = '{F3_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          FULL_LAT};
    tab[11] = '{F3_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  FULL_LAT};
    tab[12] = '{F3_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          FULL_LAT};
    for (int i = 0; i < 13; i++) begin
      run_op(tab[i].f3, tab[i].a, tab[i].b, lat, rd, ok);
      checks++;
      if (rd !== tab[i].exp) begin
        errors++;
        $display("FAIL arith[%0d]_rd got %h want %h", i, rd, tab[i].exp);
      end
      checks++;
      if (lat !== tab[i].lat) begin
        errors++;
        $display("FAIL arith[%0d]_latency got %0d want %0d", i, lat, tab[i].lat);
      end
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL arith[%0d]_handshake got %b want 1", i, ok);
      end
    end
  endtask

  // Non-divide encodings must not be claimed.
  task automatic test_ignore;
    logic [31:0] bad [3];
    logic        claimed;
    bad[0] = {FUNCT7_MULDIV, 5'd2, 5'd1, 3'b000, 5'd3, OPCODE_OP};  // MUL
    bad[1] = {7'b0100000,    5'd2, 5'd1, F3_DIV, 5'd3, OPCODE_OP};  // funct7 mismatch
    bad[2] = {FUNCT7_MULDIV, 5'd2, 5'd1, F3_DIV, 5'd3, 7'b0010011}; // opcode mismatch
    for (int i = 0; i < 3; i++) begin
      claimed = 1'b0;
      @(posedge clk);
      #1;
      pcpi_valid = 1'b1;
      pcpi_insn  = bad[i];
      pcpi_rs1   = 32'd10;
      pcpi_rs2   = 32'd2;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0) claimed = 1'b1;
      end
      pcpi_valid = 1'b0;
      checks++;
      if (claimed !== 1'b0) begin
        errors++;
        $display("FAIL ignore[%0d] claimed got %b want 0", i, claimed);
      end
    end
  endtask

  task automatic test_abort;
    logic        seen_ready;
    logic        wait_t7;
    int          lat;
    logic [31:0] rd;
    logic        ok;
    seen_ready = 1'b0;
    wait_t7    = 1'b1;
    @(posedge clk);
    #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(F3_DIVU);
    pcpi_rs1   = 32'd50;
    pcpi_rs2   = 32'd5;
    @(posedge clk);           // edge ending T
    repeat (4) @(posedge clk); // now in cycle T+5
    #1 pcpi_valid = 1'b0;
    for (int c = 5; c <= 45; c++) begin
      @(negedge clk);
      if (pcpi_ready !== 1'b0) seen_ready = 1'b1;
      if (c == 7) wait_t7 = pcpi_wait;
    end
    checks++;
    if (seen_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", seen_ready); end
    checks++;
    if (wait_t7 !== 1'b0) begin errors++; $display("FAIL abort_wait_t7 got %b want 0", wait_t7); end
    // Same operands again: an aborted op must not have produced a cache hit.
    run_op(F3_DIVU, 32'd50, 32'd5, lat, rd, ok);
    checks++;
    if (rd !== 32'd10 || lat !== FULL_LAT || ok !== 1'b1) begin
      errors++;
      $display("FAIL abort_retry got rd=%h lat=%0d ok=%b want rd=0000000a lat=%0d ok=1", rd, lat, ok, FULL_LAT);
    end
    run_op(F3_DIVU, 32'd9, 32'd3, lat, rd, ok);
    checks++;
    if (rd !== 32'd3 || lat !== FULL_LAT || ok !== 1'b1) begin
      errors++;
      $display("FAIL abort_next got rd=%h lat=%0d ok=%b want rd=00000003 lat=%0d ok=1", rd, lat, ok, FULL_LAT);
    end
  endtask

  task automatic test_reset_mid_run;
    int          lat;
    logic [31:0] rd;
    logic        ok;
    @(posedge clk);
    #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(F3_DIVU);
    pcpi_rs1   = 32'd1000;
    pcpi_rs2   = 32'd7;
    @(posedge clk);            // edge ending T
    repeat (3) @(posedge clk); // cycle T+4, in RUN
    @(negedge clk);
    checks++;
    if (pcpi_wait !== 1'b1) begin errors++; $display("FAIL midrun_wait got %b want 1", pcpi_wait); end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({pcpi_wait, pcpi_ready, pcpi_wr} !== 3'b000 || pcpi_rd !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset got wait=%b ready=%b wr=%b rd=%h want all 0",
               pcpi_wait, pcpi_ready, pcpi_wr, pcpi_rd);
    end
    pcpi_valid = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    // 9/3 was the last completed op; reset must have dropped it from any cache.
    run_op(F3_DIVU, 32'd9, 32'd3, lat, rd, ok);
    checks++;
    if (rd !== 32'd3 || lat !== FULL_LAT || ok !== 1'b1) begin
      errors++;
      $display("FAIL midrun_recover got rd=%h lat=%0d ok=%b want rd=00000003 lat=%0d ok=1", rd, lat, ok, FULL_LAT);
    end
  endtask

  task automatic test_cache;
    int          lat;
    logic [31:0] rd;
    logic        ok;
    run_op(F3_DIV, 32'd1000, 32'd3, lat, rd, ok);
    checks++;
    if (rd !== 32'd333 || lat !== FULL_LAT || ok !== 1'b1) begin
      errors++;
      $display("FAIL cache_div got rd=%0d lat=%0d ok=%b want rd=333 lat=%0d ok=1", rd, lat, ok, FULL_LAT);
    end
    run_op(F3_REM, 32'd1000, 32'd3, lat, rd, ok);
    checks++;
    if (rd !== 32'd1 || lat !== HIT_LAT || ok !== 1'b1) begin
      errors++;
      $display("FAIL cache_rem got rd=%0d lat=%0d ok=%b want rd=1 lat=%0d ok=1", rd, lat, ok, HIT_LAT);
    end
  endtask

  // pcpi_valid stays high across DONE while the core swaps in the next op;
  // the next decode must happen only in the IDLE cycle after DONE.
  task automatic test_back_to_back;
    int          lat;
    logic [31:0] rd;
    logic        ok;
    @(posedge clk);
    #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(F3_DIVU);
    pcpi_rs1   = 32'd100;
    pcpi_rs2   = 32'd7;
    @(posedge clk);
    wait_ready(lat, rd, ok);
    checks++;
    if (rd !== 32'd14 || lat !== FULL_LAT || ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got rd=%0d lat=%0d ok=%b want rd=14 lat=%0d ok=1", rd, lat, ok, FULL_LAT);
    end
    pcpi_insn = mk_insn(F3_DIVU);
    pcpi_rs1  = 32'd81;
    pcpi_rs2  = 32'd9;
    @(negedge clk);  // IDLE cycle after DONE
    checks++;
    if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got wait=%b ready=%b want 0 0", pcpi_wait, pcpi_ready);
    end
    @(posedge clk);  // edge ending the second T
    wait_ready(lat, rd, ok);
    pcpi_valid = 1'b0;
    checks++;
    if (rd !== 32'd9 || lat !== FULL_LAT || ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got rd=%0d lat=%0d ok=%b want rd=9 lat=%0d ok=1", rd, lat, ok, FULL_LAT);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_arith;
    test_ignore;
    test_abort;
    test_reset_mid_run;
    test_cache;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
